// File: rtl/sprite_renderer.sv
// Sprite compositing stage: generates sprite VRAM reads from VGA timing and
// overlays the returned word on the background with a fixed 3-clock latency.
module sprite_renderer #(
  parameter int unsigned DATA_WIDTH = 13,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned SPR_W      = 64,
  parameter int unsigned SPR_H      = 64,
  parameter int unsigned NUM_FRAMES = 8,
  parameter int unsigned FRAME_DIV  = 6,
  parameter int unsigned V_ACTIVE   = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_W-1:0]    hcount,
  input  logic [COORD_W-1:0]    vcount,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  blank_in,
  input  logic [11:0]           bg_rgb,
  input  logic [COORD_W-1:0]    sprite_x,
  input  logic [COORD_W-1:0]    sprite_y,
  input  logic                  sprite_on,
  input  logic                  anim_run,
  output logic                  vram_en,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  input  logic [DATA_WIDTH-1:0] vram_data,
  output logic [11:0]           rgb_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  blank_out
);

  localparam int unsigned CW1     = COORD_W + 1;
  localparam int unsigned DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned FRM_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned SPR_PIX = SPR_W * SPR_H;
  localparam int unsigned OPQ_BIT = DATA_WIDTH - 1;

  // Per-frame shadow of the sprite request and animation state
  logic [COORD_W-1:0] sx_q, sy_q;
  logic               on_q;
  logic [FRM_W-1:0]   frame_q;
  logic [DIV_W-1:0]   div_q;

  // Sync/blank/background delay line (stages 1 and 2)
  logic [11:0] bg_d1, bg_d2;
  logic        hs_d1, hs_d2, vs_d1, vs_d2, bl_d1, bl_d2;

  logic                  frame_latch_c;
  logic                  in_box_c;
  logic [CW1-1:0]        h_ext_c, v_ext_c, x_hi_c, y_hi_c, col_off_c, row_off_c;
  logic [ADDR_WIDTH-1:0] addr_c;

  assign frame_latch_c = (hcount == '0) && (vcount == COORD_W'(V_ACTIVE));

  // Hit test against the latched box at one extra bit so the right/bottom edge never wraps
  always_comb begin
    h_ext_c   = {1'b0, hcount};
    v_ext_c   = {1'b0, vcount};
    x_hi_c    = {1'b0, sx_q} + CW1'(SPR_W);
    y_hi_c    = {1'b0, sy_q} + CW1'(SPR_H);
    col_off_c = h_ext_c - {1'b0, sx_q};
    row_off_c = v_ext_c - {1'b0, sy_q};
    in_box_c  = on_q && !blank_in &&
                (h_ext_c >= {1'b0, sx_q}) && (h_ext_c < x_hi_c) &&
                (v_ext_c >= {1'b0, sy_q}) && (v_ext_c < y_hi_c);
    addr_c    = ADDR_WIDTH'(32'(frame_q) * 32'(SPR_PIX) +
                            32'(row_off_c) * 32'(SPR_W) + 32'(col_off_c));
  end

  // Latch position at the start of vertical blank and step the animation divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      on_q    <= 1'b0;
      frame_q <= '0;
      div_q   <= '0;
    end else if (frame_latch_c) begin
      sx_q <= sprite_x;
      sy_q <= sprite_y;
      on_q <= sprite_on;
      if (anim_run) begin
        if (div_q == DIV_W'(FRAME_DIV - 1)) begin
          div_q   <= '0;
          frame_q <= (frame_q == FRM_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FRM_W'(1);
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end
    end
  end

  // Stage 1: issue the VRAM read and start the timing delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_en   <= 1'b0;
      vram_addr <= '0;
      bg_d1     <= '0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      bl_d1     <= 1'b1;
    end else begin
      vram_en   <= in_box_c;
      vram_addr <= in_box_c ? addr_c : '0;
      bg_d1     <= bg_rgb;
      hs_d1     <= hsync_in;
      vs_d1     <= vsync_in;
      bl_d1     <= blank_in;
    end
  end

  // Stage 2: hold timing while the VRAM performs its registered read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_d2 <= '0;
      hs_d2 <= 1'b1;
      vs_d2 <= 1'b1;
      bl_d2 <= 1'b1;
    end else begin
      bg_d2 <= bg_d1;
      hs_d2 <= hs_d1;
      vs_d2 <= vs_d1;
      bl_d2 <= bl_d1;
    end
  end

  // Stage 3: composite opaque sprite texels over the background, black in blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      rgb_out   <= bl_d2 ? 12'h000 : (vram_data[OPQ_BIT] ? vram_data[11:0] : bg_d2);
      hsync_out <= hs_d2;
      vsync_out <= vs_d2;
      blank_out <= bl_d2;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a behavioural VRAM and a scoreboard.
module tb_sprite_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount, sprite_x, sprite_y;
  logic        hsync_in, vsync_in, blank_in, sprite_on, anim_run;
  logic [11:0] bg_rgb;
  logic        vram_en;
  logic [14:0] vram_addr;
  logic [12:0] vram_data = '0;
  logic [11:0] rgb_out;
  logic        hsync_out, vsync_out, blank_out;

  sprite_renderer dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in), .bg_rgb(bg_rgb),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_on(sprite_on), .anim_run(anim_run),
    .vram_en(vram_en), .vram_addr(vram_addr), .vram_data(vram_data),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
  );

  always #5 clk = ~clk;

  // Behavioural sprite VRAM: 1-cycle registered read, 0 when not enabled
  logic [12:0] mem [0:32767];
  always @(posedge clk) vram_data <= vram_en ? mem[vram_addr] : 13'h0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int n; int h; int v; logic en; logic [14:0] addr; } e1_t;
  typedef struct { int n; int h; int v; logic [11:0] rgb; logic hs; logic vs; logic bl; } e3_t;
  e1_t q1[$];
  e3_t q3[$];
  e1_t a1;
  e3_t a3;

  int checks = 0;
  int failures = 0;

  // Reference state of the sprite block
  int m_sx, m_sy, m_frame, m_div;
  bit m_on;

  task automatic chk(input string tag, input int h, input int v,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s h=%0d v=%0d got=%0h exp=%0h", tag, h, v, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_on = 0; m_frame = 0; m_div = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rgb"},   0, 0, 32'(rgb_out),   32'h0);
    chk({tag, "_blank"}, 0, 0, 32'(blank_out), 32'h1);
    chk({tag, "_hsync"}, 0, 0, 32'(hsync_out), 32'h1);
    chk({tag, "_vsync"}, 0, 0, 32'(vsync_out), 32'h1);
    chk({tag, "_en"},    0, 0, 32'(vram_en),   32'h0);
    chk({tag, "_addr"},  0, 0, 32'(vram_addr), 32'h0);
  endtask

  // Drive one pixel and push its expected stage-1 and stage-3 results
  task automatic drive(input int h, input int v, input bit force_act);
    bit bl, hs, vs, en;
    int addr;
    logic [11:0] bg, rgb;
    logic [12:0] w;
    e1_t x1;
    e3_t x3;
    @(posedge clk); #1;
    bl = force_act ? 1'b0 : (h >= 640 || v >= 480);
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    bg = 12'(h * 3 + v * 17 + 'h123);
    hcount = 10'(h); vcount = 10'(v);
    hsync_in = hs; vsync_in = vs; blank_in = bl; bg_rgb = bg;
    en = m_on && !bl && h >= m_sx && h < m_sx + 64 && v >= m_sy && v < m_sy + 64;
    addr = en ? (m_frame * 4096 + (v - m_sy) * 64 + (h - m_sx)) % 32768 : 0;
    w = en ? mem[addr] : 13'h0000;
    rgb = bl ? 12'h000 : (w[12] ? w[11:0] : bg);
    x1.n = cyc; x1.h = h; x1.v = v; x1.en = en; x1.addr = 15'(addr);
    x3.n = cyc; x3.h = h; x3.v = v; x3.rgb = rgb; x3.hs = hs; x3.vs = vs; x3.bl = bl;
    q1.push_back(x1);
    q3.push_back(x3);
    if (h == 0 && v == 480) begin
      m_sx = int'(sprite_x); m_sy = int'(sprite_y); m_on = sprite_on;
      if (anim_run) begin
        if (m_div == 5) begin
          m_div = 0;
          m_frame = (m_frame + 1) % 8;
        end else begin
          m_div++;
        end
      end
    end
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) drive(h, v, 1'b0);
  endtask

  task automatic latch();
    drive(0, 480, 1'b0);
    drive(1, 480, 1'b0);
  endtask

  task automatic idle_inputs();
    hcount = 10'd700; vcount = 10'd10; hsync_in = 1'b1; vsync_in = 1'b1;
    blank_in = 1'b1; bg_rgb = 12'h000;
  endtask

  // Scoreboard: compare stage-1 outputs one clock and pixel outputs three clocks after drive
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].n + 1 == cyc) begin
      a1 = q1.pop_front();
      chk("vram_en",   a1.h, a1.v, 32'(vram_en),   32'(a1.en));
      chk("vram_addr", a1.h, a1.v, 32'(vram_addr), 32'(a1.addr));
    end
    if (q3.size() > 0 && q3[0].n + 3 == cyc) begin
      a3 = q3.pop_front();
      chk("rgb_out",   a3.h, a3.v, 32'(rgb_out),   32'(a3.rgb));
      chk("hsync_out", a3.h, a3.v, 32'(hsync_out), 32'(a3.hs));
      chk("vsync_out", a3.h, a3.v, 32'(vsync_out), 32'(a3.vs));
      chk("blank_out", a3.h, a3.v, 32'(blank_out), 32'(a3.bl));
    end
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 13'((i * 37) ^ (i >> 4));
    mem[0]    = 13'h1ABC;
    mem[1]    = 13'h0DEF;
    mem[4095] = 13'h1F0F;
    mem[4096] = 13'h1555;
    rst_n = 1'b0;
    idle_inputs();
    sprite_x = 10'd100; sprite_y = 10'd50; sprite_on = 1'b1; anim_run = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 chk_reset("reset");

    // Release mid-frame: sprite stays hidden until the first latch
    @(posedge clk); #3 rst_n = 1'b1;
    line(50, 95, 170);
    line(10, 630, 760);
    for (int v = 487; v <= 493; v++) drive(5, v, 1'b0);

    latch();
    line(50, 95, 170);
    line(113, 155, 170);
    drive(164, 50, 1'b0);

    // Position change mid-frame only takes effect at the next latch
    sprite_x = 10'd200;
    line(51, 95, 170);
    latch();
    line(51, 195, 270);

    // Animation stepping, wrap and hold
    anim_run = 1'b1;
    repeat (6) latch();
    line(50, 198, 203);
    repeat (42) latch();
    line(50, 198, 203);
    repeat (12) latch();
    anim_run = 1'b0;
    repeat (10) latch();
    line(50, 198, 203);

    // Right-edge clipping near the visible edge
    sprite_x = 10'd620;
    latch();
    line(60, 600, 639);
    line(61, 0, 50);

    // Right-edge clipping at the coordinate limit, forced active to expose any wrap
    sprite_x = 10'd1000;
    latch();
    for (int h = 990; h <= 1023; h++) drive(h, 60, 1'b1);
    for (int h = 0; h <= 40; h++) drive(h, 61, 1'b1);

    // Reset asserted mid-line while the sprite is being drawn
    sprite_x = 10'd100;
    latch();
    line(55, 95, 120);
    @(posedge clk); #3 rst_n = 1'b0;
    q1.delete();
    q3.delete();
    model_reset();
    #1 chk_reset("async_rst");
    repeat (2) @(posedge clk);
    #1 chk_reset("held_rst");
    idle_inputs();
    #2 rst_n = 1'b1;
    line(55, 95, 170);
    latch();
    line(55, 95, 170);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && (q1.size() > 0 || q3.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    chk("drain", 0, 0, 32'(q1.size() + q3.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Pixel-pipeline stage directly upstream of the sprite VRAM. It takes VGA timing (hcount/vcount/syncs/blank) and the background pixel.
- It generates the VRAM read enable and address for an animated player sprite, then composites the returned VRAM word over the background.
- It delays syncs and blank to match the VRAM's 1-cycle registered read.
- Output feeds the VGA output register stage.

Parameters:
- DATA_WIDTH, 13: VRAM word width. Bit 12 is the opaque flag; bits 11:0 are RGB444.
- ADDR_WIDTH, 15: VRAM address width.
- COORD_W, 10: width of hcount/vcount/sprite position.
- SPR_W, 64: sprite width in pixels (power of 2).
- SPR_H, 64: sprite height in pixels (power of 2).
- NUM_FRAMES, 8: animation frames stored back-to-back in VRAM (power of 2).
- FRAME_DIV, 6: video frames per animation step (>=1).
- V_ACTIVE, 480: first non-visible line; the frame-latch point.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount  in  COORD_W  current pixel column
- vcount  in  COORD_W  current pixel row
- hsync_in  in  1  active-low hsync
- vsync_in  in  1  active-low vsync
- blank_in  in  1  1 = outside active video
- bg_rgb  in  12  background pixel for this (hcount, vcount)
- sprite_x  in  COORD_W  requested sprite left edge
- sprite_y  in  COORD_W  requested sprite top edge
- sprite_on  in  1  sprite visible request
- anim_run  in  1  1 = animation advances
- vram_en  out  1  to VRAM en
- vram_addr  out  ADDR_WIDTH  to VRAM addr
- vram_data  in  DATA_WIDTH  from VRAM data (valid 1 cycle after en/addr)
- rgb_out  out  12  composited pixel
- hsync_out  out  1  delayed hsync
- vsync_out  out  1  delayed vsync
- blank_out  out  1  delayed blank

Behaviour:
- **Reset (async, rst_n=0):**
  - vram_en=0, vram_addr=0, rgb_out=0, blank_out=1, hsync_out=1, vsync_out=1.
  - All sync/blank pipeline regs reset to the same values.
  - Shadow position = 0, shadow on = 0, anim frame = 0, div counter = 0.
- **Frame latch:** on the cycle with hcount==0 && vcount==V_ACTIVE:
  - Latch sprite_x, sprite_y, sprite_on into shadow regs. Position never changes mid-frame.
  - If anim_run: div counter increments. When it reaches FRAME_DIV-1 it wraps to 0 and the frame index increments mod NUM_FRAMES.
  - If anim_run=0: div counter and frame index hold.
- **Stage 1 (edge after input cycle N):**
  - in_box = shadow_on && !blank_in && hcount>=sx && hcount<sx+SPR_W && vcount>=sy && vcount<sy+SPR_H.
  - Bounds compare at COORD_W+1 bits; no wrap. A sprite partly off-screen is clipped.
  - vram_en <= in_box.
  - vram_addr <= in_box ? frame*SPR_W*SPR_H + (vcount-sy)*SPR_W + (hcount-sx) : 0, truncated to ADDR_WIDTH.
  - bg_rgb, hsync_in, vsync_in, blank_in enter the delay line.
- **Stage 2 (VRAM registers data):** vram_data is valid during cycle N+2. When en was 0 the VRAM returns 0, i.e. transparent.
- **Stage 3 (edge ending cycle N+2):**
  - rgb_out <= delayed blank ? 0 : (vram_data[12] ? vram_data[11:0] : delayed bg).
  - hsync_out, vsync_out, blank_out take their 3-cycle-delayed values.
- **Latency:** exactly 3 clocks from inputs to rgb/sync/blank outputs, every cycle, no stalls.
- **Blanking:** rgb_out=0 whenever blank_out=1, regardless of VRAM contents.
- **Boundaries:**
  - Sprite at sx >= 2^COORD_W - SPR_W is clipped, no wrap to column 0.
  - Frame index wraps NUM_FRAMES-1 -> 0.
  - Reset deasserting mid-frame: sprite stays hidden (shadow_on=0) until the next frame latch.

Test Plan:
- Reset, then run 640x480 timing with sprite_on=1, sprite_x=100, sprite_y=50 → no sprite pixels in the first frame. After the latch, at hcount=100/vcount=50: vram_en=1, vram_addr=0. At (163,113): addr=4095. At (164,50): vram_en=0.
- VRAM model with opaque word 13'h1ABC at addr 0, bg_rgb=12'h123 → rgb_out=12'hABC exactly 3 clocks after hcount=100/vcount=50. A word with bit12=0 yields 12'h123.
- Change sprite_x to 200 mid-frame → addressing still uses x=100 until vcount==480/hcount==0, then the next frame uses 200.
- anim_run=1, FRAME_DIV=6 → after 6 latches the frame index is 1 and the first sprite pixel addr=4096. After 48 latches it has wrapped to 0. anim_run=0 holds the index.
- sprite_x=620 → vram_en=1 only for hcount 620..639, addr column offsets 0..19, never at hcount 0..43.
- Assert rst_n low mid-line → outputs immediately rgb_out=0, blank_out=1, syncs=1, vram_en=0. After release, the sprite is hidden until the next latch; hsync_out always matches hsync_in delayed by 3.
